// File: rtl/cdce_cfg_pkg.sv
// Shared definitions for the CDCE configuration sequencer: command opcodes,
// sequencer states, SPI frame geometry and the frame packing helper.
package cdce_cfg_pkg;

    localparam int FRAME_W = 32;
    localparam int CMD_W   = 24;
    localparam int OP_MSB  = 23;
    localparam int OP_LSB  = 20;
    localparam int HI_W    = 12;

    localparam logic [3:0] OP_END     = 4'h0;
    localparam logic [3:0] OP_LOAD_HI = 4'h1;
    localparam logic [3:0] OP_WRITE   = 4'h2;
    localparam logic [3:0] OP_WAIT    = 4'h3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_SHIFT,
        ST_GAP,
        ST_WAIT,
        ST_DONE,
        ST_ERROR,
        ST_LOCKWAIT
    } seq_state_t;

    // 28 data bits (upper 12 from LOAD_HI) followed by the 4-bit register address
    function automatic logic [FRAME_W-1:0] build_frame(input logic [HI_W-1:0] hi,
                                                       input logic [19:0]     payload);
        return {hi, payload[15:0], payload[19:16]};
    endfunction

endpackage

// File: rtl/cdce_spi_shifter.sv
// 32-bit LSB-first serializer for the CDCE 4-wire SPI.  A frame is 66
// half-periods of CLK_DIV clocks with LE low: one lead-in, 32 high/low SCLK
// pairs, one trailing hold.  frame_done marks the last cycle of the frame.
module cdce_spi_shifter
    import cdce_cfg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame,
    output logic               sclk,
    output logic               le,
    output logic               mosi,
    output logic               frame_done
);

    localparam int               HALF_LAST = 2 * FRAME_W + 1;
    localparam logic [15:0]      DIV_LAST  = 16'(CLK_DIV - 1);

    logic [15:0]        div_cnt;
    logic [6:0]         half;
    logic               active;
    logic [FRAME_W-1:0] sr;
    logic               half_end;

    assign half_end   = active && (div_cnt == DIV_LAST);
    assign frame_done = half_end && (half == 7'(HALF_LAST));
    assign mosi       = sr[0];

    // Half-period sequencing: SCLK rises entering odd halves, falls (and the
    // next bit is presented) entering even halves 2..64.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            half    <= '0;
            active  <= 1'b0;
            sr      <= '0;
            sclk    <= 1'b0;
            le      <= 1'b1;
        end else if (load && !active) begin
            active  <= 1'b1;
            le      <= 1'b0;
            sclk    <= 1'b0;
            sr      <= frame;
            div_cnt <= '0;
            half    <= '0;
        end else if (active) begin
            if (!half_end) begin
                div_cnt <= div_cnt + 16'd1;
            end else begin
                div_cnt <= '0;
                if (half == 7'(HALF_LAST)) begin
                    active <= 1'b0;
                    le     <= 1'b1;
                    sclk   <= 1'b0;
                    sr     <= '0;
                end else begin
                    half <= half + 7'd1;
                    if (!half[0]) begin
                        if (half != 7'(2 * FRAME_W))
                            sclk <= 1'b1;
                    end else begin
                        sclk <= 1'b0;
                        sr   <= sr >> 1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cdce_config_sequencer.sv
// Walks the CDCE command ROM after a start pulse, decodes each command and
// issues SPI register writes through cdce_spi_shifter.
// Optional: define CDCE_PLL_LOCK_WAIT_EN to add the pll_lock input and a
// post-END lock wait with LOCK_TIMEOUT.
module cdce_config_sequencer
    import cdce_cfg_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 8
`ifdef CDCE_PLL_LOCK_WAIT_EN
    ,
    parameter int LOCK_TIMEOUT = 1_000_000
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [CMD_W-1:0]  rom_command,
    output logic              spi_sclk,
    output logic              spi_le,
    output logic              spi_mosi,
    output logic              busy,
    output logic              done,
    output logic              error
`ifdef CDCE_PLL_LOCK_WAIT_EN
    ,
    input  logic              pll_lock
`endif
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [15:0]       GAP_LAST  = 16'(2 * CLK_DIV - 1);

    seq_state_t         state;
    logic [HI_W-1:0]    hi_reg;
    logic [19:0]        wait_cnt;
    logic [15:0]        gap_cnt;
    logic [3:0]         opcode;
    logic [19:0]        payload;
    logic               spi_load;
    logic               frame_done;
    logic               advance;
    logic [FRAME_W-1:0] spi_frame;

    assign opcode    = rom_command[OP_MSB:OP_LSB];
    assign payload   = rom_command[19:0];
    assign spi_frame = build_frame(hi_reg, payload);
    assign spi_load  = (state == ST_DECODE) && (opcode == OP_WRITE);

    // Every path that moves on to the next ROM word funnels through one flag
    always_comb begin
        advance = 1'b0;
        case (state)
            ST_DECODE: advance = (opcode == OP_LOAD_HI) ||
                                 ((opcode == OP_WAIT) && (payload == '0));
            ST_WAIT:   advance = (wait_cnt == 20'd1);
            ST_GAP:    advance = (gap_cnt == GAP_LAST);
            default:   advance = 1'b0;
        endcase
    end

    // Upper frame bits captured by LOAD_HI
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hi_reg <= '0;
        else if ((state == ST_DECODE) && (opcode == OP_LOAD_HI))
            hi_reg <= payload[HI_W-1:0];
    end

`ifdef CDCE_PLL_LOCK_WAIT_EN
    localparam logic [31:0] LOCK_LAST = 32'(LOCK_TIMEOUT - 1);
    logic        lock_meta, lock_sync, lock_prev;
    logic [31:0] lock_cnt;

    // Two-flop synchronizer plus one extra sample for the two-in-a-row test
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            lock_prev <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_sync <= lock_meta;
            lock_prev <= lock_sync;
        end
    end
`endif

    // Main sequencer FSM with address counter, WAIT and GAP counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            rom_address <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
`ifdef CDCE_PLL_LOCK_WAIT_EN
            lock_cnt    <= '0;
`endif
        end else if (advance) begin
            if (rom_address == ADDR_LAST) begin
                state <= ST_ERROR;
                busy  <= 1'b0;
                error <= 1'b1;
            end else begin
                rom_address <= rom_address + ADDR_W'(1);
                state       <= ST_FETCH;
            end
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        rom_address <= '0;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    case (opcode)
                        OP_END: begin
`ifdef CDCE_PLL_LOCK_WAIT_EN
                            lock_cnt <= '0;
                            state    <= ST_LOCKWAIT;
`else
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`endif
                        end
                        OP_LOAD_HI: state <= ST_FETCH;
                        OP_WRITE:   state <= ST_SHIFT;
                        OP_WAIT: begin
                            wait_cnt <= payload;
                            state    <= ST_WAIT;
                        end
                        default: begin
                            state <= ST_ERROR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    endcase
                end
                ST_SHIFT: begin
                    if (frame_done) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP:  gap_cnt  <= gap_cnt + 16'd1;
                ST_WAIT: wait_cnt <= wait_cnt - 20'd1;
`ifdef CDCE_PLL_LOCK_WAIT_EN
                ST_LOCKWAIT: begin
                    if (lock_sync && lock_prev) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state <= ST_ERROR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + 32'd1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    cdce_spi_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (spi_load),
        .frame     (spi_frame),
        .sclk      (spi_sclk),
        .le        (spi_le),
        .mosi      (spi_mosi),
        .frame_done(frame_done)
    );

endmodule

// File: tb/tb_cdce_config_sequencer.sv
// Bench for cdce_config_sequencer: directed and random ROM programs checked
// against a command-level reference model (frames, final address, flags,
// busy duration) plus SPI protocol monitors.
module tb_cdce_config_sequencer;

    localparam int CLK_DIV = 2;
    localparam int ADDR_W  = 3;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] rom_address;
    logic [23:0]       rom_command;
    logic              spi_sclk, spi_le, spi_mosi, busy, done, error;

    always #5 clk = ~clk;

    cdce_config_sequencer #(
        .CLK_DIV(CLK_DIV),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .rom_address(rom_address),
        .rom_command(rom_command),
        .spi_sclk   (spi_sclk),
        .spi_le     (spi_le),
        .spi_mosi   (spi_mosi),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Registered command ROM
    logic [23:0] rom [DEPTH];
    always @(posedge clk) rom_command <= rom[rom_address];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SPI / busy monitor sampled on the falling clock edge
    logic        prev_sclk = 1'b0, prev_le = 1'b1, prev_mosi = 1'b0;
    logic [31:0] cap = '0;
    int          nbits = 0, got_n = 0, busy_cyc = 0, viol = 0, rises = 0, le_low = 0;
    logic [31:0] got_fr [64];

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cyc++;
        if (spi_le === 1'b0) le_low++;
        if (prev_le && !spi_le) nbits = 0;
        if (!prev_sclk && spi_sclk) begin
            cap = {spi_mosi, cap[31:1]};
            nbits++;
            rises++;
        end
        if (prev_sclk && spi_sclk && (spi_mosi !== prev_mosi)) viol++;
        if (spi_sclk && spi_le) viol++;
        if (!prev_le && spi_le && nbits == 32 && got_n < 64) begin
            got_fr[got_n] = cap;
            got_n++;
        end
        prev_sclk = spi_sclk;
        prev_le   = spi_le;
        prev_mosi = spi_mosi;
    end

    // Command-level reference model
    logic [11:0] m_hi;
    logic [31:0] e_fr [64];
    int          e_n, e_addr, e_busy;
    logic        e_done, e_err;

    task automatic model_run();
        int a;
        bit fin;
        a = 0; fin = 0; e_n = 0; e_busy = 0; e_done = 0; e_err = 0;
        while (!fin) begin
            logic [3:0]  op;
            logic [19:0] pl;
            bit          adv;
            op  = rom[a][23:20];
            pl  = rom[a][19:0];
            adv = 0;
            e_busy += 2;
            case (op)
                4'h0: begin e_done = 1; fin = 1; end
                4'h1: begin m_hi = pl[11:0]; adv = 1; end
                4'h2: begin
                    e_fr[e_n] = (32'(m_hi) * 32'h0010_0000) + (32'(pl % 65536) * 16) + 32'(pl / 65536);
                    e_n++;
                    e_busy += CLK_DIV * (1 + 64 + 1 + 2);
                    adv = 1;
                end
                4'h3: begin e_busy += int'(pl); adv = 1; end
                default: begin e_err = 1; fin = 1; end
            endcase
            if (adv) begin
                if (a == DEPTH - 1) begin e_err = 1; fin = 1; end
                else a++;
            end
        end
        e_addr = a;
    endtask

    task automatic run_prog(input string tag, input bit inject, output int meas_busy);
        int b0, g0, v0, r0, l0, ng;
        bit fin, injected;
        b0 = busy_cyc; g0 = got_n; v0 = viol; r0 = rises; l0 = le_low;
        fin = 0; injected = 0;
        model_run();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
            @(negedge clk);
            #1;
            if (inject && !injected && nbits == 5 && !spi_le) begin
                start = 1'b1;
                injected = 1;
            end else begin
                start = 1'b0;
            end
            if (done || error) fin = 1;
        end
        start = 1'b0;
        check_eq($sformatf("%s_finished", tag), 32'(fin), 32'd1);
        @(negedge clk);
        #1;
        meas_busy = busy_cyc - b0;
        ng = got_n - g0;
        check_eq($sformatf("%s_done", tag), 32'(done), 32'(e_done));
        check_eq($sformatf("%s_error", tag), 32'(error), 32'(e_err));
        check_eq($sformatf("%s_addr", tag), 32'(rom_address), e_addr);
        check_eq($sformatf("%s_busy_cycles", tag), meas_busy, e_busy);
        check_eq($sformatf("%s_nframes", tag), ng, e_n);
        for (int k = 0; k < e_n && k < ng; k++)
            check_eq($sformatf("%s_frame%0d", tag, k), got_fr[g0 + k], e_fr[k]);
        check_eq($sformatf("%s_spi_viol", tag), viol - v0, 0);
        check_eq($sformatf("%s_sclk_rises", tag), rises - r0, 32 * e_n);
        check_eq($sformatf("%s_le_low_cycles", tag), le_low - l0, 66 * CLK_DIV * e_n);
        check_eq($sformatf("%s_idle_le", tag), 32'(spi_le), 32'd1);
        check_eq($sformatf("%s_idle_busy", tag), 32'(busy), 32'd0);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = 24'h000000;
    endtask

    initial begin
        int  mb, r0;
        bit  hit;
        reset_n = 1'b1;
        start   = 1'b0;
        m_hi    = '0;
        clear_rom();
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_le", 32'(spi_le), 32'd1);
        check_eq("rst_sclk", 32'(spi_sclk), 32'd0);
        check_eq("rst_mosi", 32'(spi_mosi), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_addr", 32'(rom_address), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // One LOAD_HI + WRITE, then END
        clear_rom();
        rom[0] = 24'h100ABC; rom[1] = 24'h25BEEF; rom[2] = 24'h000000;
        run_prog("t1", 0, mb);
        check_eq("t1_frame_const", got_fr[(got_n > 0) ? got_n - 1 : 0], 32'hABCBEEF5);

        // WAIT 16 then END
        clear_rom();
        rom[0] = 24'h300010;
        r0 = rises;
        run_prog("t2", 0, mb);
        check_eq("t2_wait_busy", mb, 2 + 16 + 2);
        check_eq("t2_no_sclk", rises - r0, 0);

        // Illegal opcode at address 0
        clear_rom();
        rom[0] = 24'h7ABCDE;
        run_prog("t3", 0, mb);

        // No END anywhere: overrun after the last address
        for (int i = 0; i < DEPTH; i++) rom[i] = 24'h100000;
        run_prog("t4", 0, mb);

        // Reset in the middle of a frame, then a full rerun
        clear_rom();
        rom[0] = 24'h100123; rom[1] = 24'h212345;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        hit = 0;
        for (int cyc = 0; cyc < 2000 && !hit; cyc++) begin
            @(negedge clk);
            #1;
            if (!spi_le && nbits == 10) hit = 1;
        end
        check_eq("t5_reached_bit10", 32'(hit), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("t5_rst_le", 32'(spi_le), 32'd1);
        check_eq("t5_rst_sclk", 32'(spi_sclk), 32'd0);
        check_eq("t5_rst_busy", 32'(busy), 32'd0);
        check_eq("t5_rst_addr", 32'(rom_address), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        m_hi = '0;
        run_prog("t5", 0, mb);

        // start pulsed mid-frame must be ignored
        clear_rom();
        rom[0] = 24'h1000FF; rom[1] = 24'h2ABCDE;
        run_prog("t6", 1, mb);

        // Random programs
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < DEPTH; i++) begin
                int unsigned r;
                r = $urandom_range(0, 99);
                if (r < 10)      rom[i] = {4'h0, 20'($urandom)};
                else if (r < 35) rom[i] = {4'h1, 20'($urandom)};
                else if (r < 65) rom[i] = {4'h2, 20'($urandom)};
                else if (r < 92) rom[i] = {4'h3, 20'($urandom_range(0, 12))};
                else             rom[i] = {4'($urandom_range(4, 15)), 20'($urandom)};
            end
            run_prog($sformatf("rnd%0d", t), ($urandom_range(0, 3) == 0), mb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
